ucsbece154b_mem_arbiter: RTL and testbench
==========================================

Name: ucsbece154b_mem_arbiter

Overview:
Shares the single SDRAM-controller block-read port between two requesters: the icache demand-miss path (requester 0, D) and the next-line prefetcher (requester 1, P). It selects one request per block transfer with demand priority and a prefetch anti-starvation limit. It forwards the streamed words and block index to the granted requester, or to both when their block addresses match. It sits between ucsbece154b_icache / prefetcher and the SDRAM controller.

Parameters:
BLOCK_WORDS, 4, words per SDRAM burst; must match icache BLOCK_WORDS.
STARVE_LIMIT, 3, consecutive demand grants with P pending before P is forced to win (1..15).

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-low reset (0 = reset).
d_req  in  1  demand request, level; held until d_done.
d_addr  in  32  demand address; block address = d_addr[31:2+log2(BLOCK_WORDS)].
d_dataReady  out  1  word valid to demand requester.
d_done  out  1  one-cycle pulse: demand block complete.
p_req  in  1  prefetch request, level; held until p_done.
p_addr  in  32  prefetch address.
p_dataReady  out  1  word valid to prefetcher.
p_done  out  1  one-cycle pulse: prefetch block complete.
dataOut  out  32  = memDataIn (shared by both requesters).
blockIndexOut  out  log2(BLOCK_WORDS)  = memBlockIndex.
memReadRequest  out  1  SDRAM read request.
memReadAddress  out  32  latched address of the granted request.
memDataIn  in  32  SDRAM word.
memDataReady  in  1  SDRAM word-valid / burst active.
memBlockIndex  in  log2(BLOCK_WORDS)  index of the current word.
busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, REQ, XFER, DONE. Reset (reset==0 at posedge) -> IDLE, grant=none, merge=0, starve_cnt=0, word_cnt=0, latched address=0. Every output is 0 while in reset and in IDLE, except dataOut and blockIndexOut, which always pass through.
- IDLE arbitration, evaluated only in IDLE:
  - Only d_req: grant D.
  - Only p_req: grant P.
  - Both, starve_cnt==STARVE_LIMIT: grant P.
  - Both, otherwise: grant D and starve_cnt++ (saturating at STARVE_LIMIT).
  - Any P grant clears starve_cnt to 0.
- Merge: both requests pending and block addresses equal -> grant the winner and set merge=1. Both requesters then receive the data and both done pulses fire, and starve_cnt clears.
- On any grant: latch the winner's address into memReadAddress and go to REQ next cycle. Request inputs are ignored until the following IDLE.
- REQ: memReadRequest=1. Stay until memDataReady=1, then go to XFER. The word on that first memDataReady cycle is forwarded and counted.
- Forwarding in REQ or XFER: g_dataReady = memDataReady for the granted requester (both when merge=1). Combinational, zero latency.
- word_cnt increments on each cycle with memDataReady=1 in REQ or XFER. When the BLOCK_WORDS-th word is accepted, go to DONE and clear word_cnt.
- memDataReady dropping mid-burst: hold in XFER with no forwarding and no count. The block completes only after BLOCK_WORDS valid words in total.
- DONE, one cycle: pulse g_done (both when merge=1), clear grant and merge, go to IDLE. A fresh arbitration happens in that IDLE cycle, so the minimum gap between bursts is one IDLE cycle.
- Withdrawal: if the granted requester's req drops before DONE, the burst still completes and its done still pulses. The requester discards the data.
- Mid-operation reset: returns immediately to IDLE with all outputs 0. No done pulse is issued for the aborted burst.

Test Plan:
- D only, d_addr=0x0000_0040; SDRAM raises memDataReady 3 cycles after memReadRequest for 4 words 0xA0..0xA3 -> memReadAddress=0x40; d_dataReady high 4 cycles with dataOut=0xA0..0xA3; p_dataReady=0; d_done pulses the cycle after the 4th word; busy falls with the return to IDLE.
- D and P both held continuously, distinct blocks, STARVE_LIMIT=3 -> grant order D, D, D, P, D, D, D, P; starve_cnt reads 0 after each P grant.
- Merge: d_addr=0x100, p_addr=0x10C, same cycle -> single burst; d_dataReady == p_dataReady on all 4 words; d_done and p_done pulse in the same cycle.
- Gapped burst: memDataReady pattern 1,1,0,0,1,1 -> exactly 4 forwarded words; done only after the 6th cycle.
- reset=0 asserted during XFER after 2 words -> next cycle state=IDLE, memReadRequest=0, no done pulse. A new d_req after release is granted normally.
- P granted, then d_req rises during the burst -> the P burst completes and p_done pulses; D is granted in the next IDLE cycle.

Source files
------------

// File: rtl/ucsbece154b_mem_arbiter.sv
// Arbitrates the SDRAM block-read port between icache demand misses (D) and the prefetcher (P).
// Demand wins by default; a starvation counter forces P through after STARVE_LIMIT demand wins.
module ucsbece154b_mem_arbiter #(
  parameter int unsigned BLOCK_WORDS  = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           d_req,
  input  logic [31:0]                    d_addr,
  output logic                           d_dataReady,
  output logic                           d_done,
  input  logic                           p_req,
  input  logic [31:0]                    p_addr,
  output logic                           p_dataReady,
  output logic                           p_done,
  output logic [31:0]                    dataOut,
  output logic [$clog2(BLOCK_WORDS)-1:0] blockIndexOut,
  output logic                           memReadRequest,
  output logic [31:0]                    memReadAddress,
  input  logic [31:0]                    memDataIn,
  input  logic                           memDataReady,
  input  logic [$clog2(BLOCK_WORDS)-1:0] memBlockIndex,
  output logic                           busy
);

  localparam int unsigned IdxW = $clog2(BLOCK_WORDS);
  localparam int unsigned Lsb  = 2 + IdxW;
  localparam logic [IdxW-1:0] LastCnt   = IdxW'(BLOCK_WORDS - 1);
  localparam logic [3:0]      StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StDone} state_e;

  state_e          state_q, state_d;
  logic            gnt_d_q, gnt_d_d;
  logic            gnt_p_q, gnt_p_d;
  logic            merge_q, merge_d;
  logic [3:0]      starve_q, starve_d;
  logic [IdxW-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]     addr_q, addr_d;

  logic both_req;
  logic p_win;
  logic same_blk;
  logic to_d;
  logic to_p;

  assign dataOut       = memDataIn;
  assign blockIndexOut = memBlockIndex;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      gnt_d_q    <= 1'b0;
      gnt_p_q    <= 1'b0;
      merge_q    <= 1'b0;
      starve_q   <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_d_q    <= gnt_d_d;
      gnt_p_q    <= gnt_p_d;
      merge_q    <= merge_d;
      starve_q   <= starve_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d_d    = gnt_d_q;
    gnt_p_d    = gnt_p_q;
    merge_d    = merge_q;
    starve_d   = starve_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;

    both_req = d_req && p_req;
    same_blk = d_addr[31:Lsb] == p_addr[31:Lsb];
    p_win    = !d_req || (both_req && (starve_q == StarveMax));
    to_d     = gnt_d_q || merge_q;
    to_p     = gnt_p_q || merge_q;

    d_dataReady    = 1'b0;
    p_dataReady    = 1'b0;
    d_done         = 1'b0;
    p_done         = 1'b0;
    memReadRequest = 1'b0;
    busy           = state_q != StIdle;
    memReadAddress = (state_q != StIdle) ? addr_q : '0;

    unique case (state_q)
      StIdle: begin
        if (d_req || p_req) begin
          gnt_d_d = !p_win;
          gnt_p_d = p_win;
          merge_d = both_req && same_blk;
          addr_d  = p_win ? p_addr : d_addr;
          state_d = StReq;
          // p_win already covers the saturated case, so the increment never overflows
          if (p_win || merge_d) begin
            starve_d = '0;
          end else if (both_req) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      StReq, StXfer: begin
        memReadRequest = state_q == StReq;
        d_dataReady    = memDataReady && to_d;
        p_dataReady    = memDataReady && to_p;
        if (memDataReady) begin
          if (word_cnt_q == LastCnt) begin
            word_cnt_d = '0;
            state_d    = StDone;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = StXfer;
          end
        end
      end
      StDone: begin
        d_done  = to_d;
        p_done  = to_p;
        gnt_d_d = 1'b0;
        gnt_p_d = 1'b0;
        merge_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (!reset) begin
      d_dataReady    = 1'b0;
      p_dataReady    = 1'b0;
      d_done         = 1'b0;
      p_done         = 1'b0;
      memReadRequest = 1'b0;
      memReadAddress = '0;
      busy           = 1'b0;
    end
  end

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Randomized bench for ucsbece154b_mem_arbiter: a transaction-level arbitration model predicts
// each grant; directed scenarios cover starvation order, merge, gaps, reset abort and late requests.
module tb_ucsbece154b_mem_arbiter;

  localparam int unsigned BW  = 4;
  localparam int unsigned LIM = 3;
  localparam int unsigned IW  = $clog2(BW);
  localparam int unsigned LSB = 2 + IW;
  localparam logic [31:0] LOMASK = (32'd1 << LSB) - 32'd1;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_req, p_req;
  logic [31:0]   d_addr, p_addr;
  logic          d_dataReady, d_done, p_dataReady, p_done;
  logic [31:0]   dataOut;
  logic [IW-1:0] blockIndexOut;
  logic          memReadRequest;
  logic [31:0]   memReadAddress;
  logic [31:0]   memDataIn;
  logic          memDataReady;
  logic [IW-1:0] memBlockIndex;
  logic          busy;

  ucsbece154b_mem_arbiter #(
    .BLOCK_WORDS (BW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .d_req         (d_req),
    .d_addr        (d_addr),
    .d_dataReady   (d_dataReady),
    .d_done        (d_done),
    .p_req         (p_req),
    .p_addr        (p_addr),
    .p_dataReady   (p_dataReady),
    .p_done        (p_done),
    .dataOut       (dataOut),
    .blockIndexOut (blockIndexOut),
    .memReadRequest(memReadRequest),
    .memReadAddress(memReadAddress),
    .memDataIn     (memDataIn),
    .memDataReady  (memDataReady),
    .memBlockIndex (memBlockIndex),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: starvation count and which requesters are pending
  int   m_starve;
  logic dp, pp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // who: bit0 = D receives the block, bit1 = P receives the block
  task automatic model_arb(output logic [1:0] who, output logic [31:0] addr);
    logic both;
    logic same;
    both = dp && pp;
    same = (d_addr >> LSB) == (p_addr >> LSB);
    if (both && m_starve == LIM) begin
      who = same ? 2'b11 : 2'b10;
      addr = p_addr;
      m_starve = 0;
    end else if (both) begin
      who = same ? 2'b11 : 2'b01;
      addr = d_addr;
      m_starve = same ? 0 : m_starve + 1;
    end else if (dp) begin
      who = 2'b01;
      addr = d_addr;
    end else begin
      who = 2'b10;
      addr = p_addr;
      m_starve = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    d_req = 1'b0;
    p_req = 1'b0;
    memDataReady = 1'b0;
    dp = 1'b0;
    pp = 1'b0;
    m_starve = 0;
    tick();
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rreq", memReadRequest, 0);
    check_eq("rst_addr", memReadAddress, 0);
    check_eq("rst_flags", {d_dataReady, d_done, p_dataReady, p_done}, 0);
    reset = 1'b1;
    tick();
  endtask

  // Starts in an IDLE cycle with requests already driven; ends in the following IDLE cycle.
  task automatic run_burst(input int lat, input logic use_pat, input logic [15:0] pat,
                           input logic [31:0] base, input logic rand_ev, input logic raise_d,
                           input logic [31:0] rd_addr, output logic [1:0] who,
                           output logic [31:0] obs_addr);
    logic [31:0] exp_addr;
    int   n;
    int   cyc;
    int   r;
    logic v;
    model_arb(who, exp_addr);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_rreq", memReadRequest, 0);
    tick();
    obs_addr = memReadAddress;
    check_eq("req_busy", busy, 1);
    check_eq("req_rreq", memReadRequest, 1);
    check_eq("req_addr", memReadAddress, exp_addr);
    for (int i = 0; i < lat; i++) begin
      #1;
      check_eq("lat_drdy", {p_dataReady, d_dataReady}, 0);
      tick();
      check_eq("lat_rreq", memReadRequest, 1);
    end
    n = 0;
    cyc = 0;
    while (n < BW) begin
      if (use_pat && cyc < 16) v = pat[cyc];
      else v = (n == 0 && !use_pat) || cyc >= 16 || ($urandom_range(0, 2) != 0);
      if (raise_d && cyc == 0) begin
        d_req = 1'b1;
        d_addr = rd_addr;
        dp = 1'b1;
      end
      if (rand_ev) begin
        r = $urandom_range(0, 9);
        if (r == 0 && who == 2'b01 && !pp) begin
          p_req = 1'b1;
          p_addr = $urandom;
          pp = 1'b1;
        end else if (r == 0 && who == 2'b10 && !dp) begin
          d_req = 1'b1;
          d_addr = $urandom;
          dp = 1'b1;
        end else if (r == 1 && who[0]) begin
          d_req = 1'b0;
        end
      end
      memDataReady = v;
      memDataIn = (base != 0) ? base + n : $urandom;
      memBlockIndex = IW'(n);
      #1;
      check_eq("fwd_d", d_dataReady, v & who[0]);
      check_eq("fwd_p", p_dataReady, v & who[1]);
      check_eq("dout", dataOut, memDataIn);
      check_eq("bidx", blockIndexOut, memBlockIndex);
      check_eq("early_done", {p_done, d_done}, 0);
      if (v) n++;
      cyc++;
      tick();
    end
    memDataReady = 1'b0;
    check_eq("done_d", d_done, who[0]);
    check_eq("done_p", p_done, who[1]);
    check_eq("done_busy", busy, 1);
    if (who[0]) begin
      d_req = 1'b0;
      dp = 1'b0;
    end
    if (who[1]) begin
      p_req = 1'b0;
      pp = 1'b0;
    end
    tick();
    check_eq("ret_busy", busy, 0);
    check_eq("ret_done", {p_done, d_done}, 0);
    check_eq("ret_addr", memReadAddress, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0]  who;
    logic [31:0] obs;
    logic [31:0] exp_a;
    logic [7:0]  p_turn;
    reset = 1'b0;
    d_req = 1'b0;
    p_req = 1'b0;
    d_addr = '0;
    p_addr = '0;
    memDataIn = '0;
    memDataReady = 1'b0;
    memBlockIndex = '0;
    do_reset();

    // Demand only, 3-cycle SDRAM latency, words A0..A3
    d_req = 1'b1;
    d_addr = 32'h40;
    dp = 1'b1;
    run_burst(3, 1'b1, 16'hFFFF, 32'hA0, 1'b0, 1'b0, 0, who, obs);
    check_eq("a_addr", obs, 32'h40);

    // Both held continuously, distinct blocks: D D D P D D D P
    do_reset();
    p_turn = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      if (!dp) begin
        d_req = 1'b1;
        d_addr = 32'h1000 + 32'(i) * 32'h40;
        dp = 1'b1;
      end
      if (!pp) begin
        p_req = 1'b1;
        p_addr = 32'h8000 + 32'(i) * 32'h40;
        pp = 1'b1;
      end
      exp_a = p_turn[i] ? p_addr : d_addr;
      run_burst(1, 1'b1, 16'hFFFF, 0, 1'b0, 1'b0, 0, who, obs);
      check_eq("order", obs, exp_a);
    end
    d_req = 1'b0;
    p_req = 1'b0;
    dp = 1'b0;
    pp = 1'b0;

    // Merge: same block from both requesters
    d_req = 1'b1;
    d_addr = 32'h100;
    p_req = 1'b1;
    p_addr = 32'h10C;
    dp = 1'b1;
    pp = 1'b1;
    run_burst(0, 1'b1, 16'hFFFF, 0, 1'b0, 1'b0, 0, who, obs);

    // Gapped burst 1,1,0,0,1,1
    d_req = 1'b1;
    d_addr = 32'h2C0;
    dp = 1'b1;
    run_burst(0, 1'b1, 16'h0033, 0, 1'b0, 1'b0, 0, who, obs);

    // Reset during XFER after two words
    d_req = 1'b1;
    d_addr = 32'h200;
    dp = 1'b1;
    tick();
    check_eq("abort_rreq", memReadRequest, 1);
    memDataReady = 1'b1;
    memBlockIndex = 0;
    tick();
    memBlockIndex = 1;
    tick();
    reset = 1'b0;
    memBlockIndex = 2;
    #1;
    check_eq("abort_fwd", d_dataReady, 0);
    check_eq("abort_busy0", busy, 0);
    tick();
    memDataReady = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_rreq0", memReadRequest, 0);
    check_eq("abort_done", d_done, 0);
    reset = 1'b1;
    m_starve = 0;
    #1;
    check_eq("abort_nodone", d_done, 0);
    run_burst(1, 1'b1, 16'hFFFF, 0, 1'b0, 1'b0, 0, who, obs);
    check_eq("abort_regrant", obs, 32'h200);

    // P granted, D arrives mid-burst and wins the next IDLE
    p_req = 1'b1;
    p_addr = 32'h300;
    pp = 1'b1;
    run_burst(1, 1'b1, 16'hFFFF, 0, 1'b0, 1'b1, 32'h480, who, obs);
    check_eq("late_p", obs, 32'h300);
    run_burst(0, 1'b1, 16'hFFFF, 0, 1'b0, 1'b0, 0, who, obs);
    check_eq("late_d", obs, 32'h480);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1'b1;
        d_req = 1'b1;
        d_addr = $urandom;
      end
      if (!pp && $urandom_range(0, 1) == 1) begin
        pp = 1'b1;
        p_req = 1'b1;
        if (dp && $urandom_range(0, 2) == 0) p_addr = (d_addr & ~LOMASK) | ($urandom & LOMASK);
        else p_addr = $urandom;
      end
      if (!dp && !pp) begin
        dp = 1'b1;
        d_req = 1'b1;
        d_addr = $urandom;
      end
      run_burst($urandom_range(0, 3), 1'b0, 16'h0, 0, 1'b1, 1'b0, 0, who, obs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
